// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: decodes ordered gate-sensor patterns into entry/exit events
// and keeps a saturating occupancy count. Define PARKING_SYNC_EN to add 2-flop sensor synchronizers.
module parking_lot_ctrl #(
   parameter int CAPACITY = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor_a,
   input  logic             sensor_b,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             enter_pulse,
   output logic             exit_pulse,
   output logic             reject
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] IN_A   = 3'd1;
   localparam logic [2:0] IN_AB  = 3'd2;
   localparam logic [2:0] IN_B   = 3'd3;
   localparam logic [2:0] OUT_B  = 3'd4;
   localparam logic [2:0] OUT_BA = 3'd5;
   localparam logic [2:0] OUT_A  = 3'd6;
   localparam logic [2:0] ABORT  = 3'd7;

   localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [1:0]       sens;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             enter_q, enter_d;
   logic             exit_q, exit_d;
   logic             reject_q, reject_d;
   logic             entry_evt, exit_evt;
   logic             at_full, at_empty;

`ifdef PARKING_SYNC_EN
   logic [1:0] sync_a_q, sync_a_d;
   logic [1:0] sync_b_q, sync_b_d;

   always_comb begin
      sync_a_d = {sync_a_q[0], sensor_a};
      sync_b_d = {sync_b_q[0], sensor_b};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a_q <= 2'b00;
         sync_b_q <= 2'b00;
      end else begin
         sync_a_q <= sync_a_d;
         sync_b_q <= sync_b_d;
      end
   end

   assign sens = {sync_a_q[1], sync_b_q[1]};
`else
   assign sens = {sensor_a, sensor_b};
`endif

   // Pattern decoder: unlisted inputs (the unchanged pattern) hold the state.
   always_comb begin
      state_d   = state_q;
      entry_evt = 1'b0;
      exit_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            case (sens)
               2'b10:   state_d = IN_A;
               2'b01:   state_d = OUT_B;
               2'b11:   state_d = ABORT;
               default: state_d = IDLE;
            endcase
         end
         IN_A: begin
            case (sens)
               2'b11:   state_d = IN_AB;
               2'b00:   state_d = IDLE;
               2'b01:   state_d = ABORT;
               default: state_d = IN_A;
            endcase
         end
         IN_AB: begin
            case (sens)
               2'b01:   state_d = IN_B;
               2'b10:   state_d = IN_A;
               2'b00:   state_d = ABORT;
               default: state_d = IN_AB;
            endcase
         end
         IN_B: begin
            case (sens)
               2'b00: begin
                  state_d   = IDLE;
                  entry_evt = 1'b1;
               end
               2'b11:   state_d = IN_AB;
               2'b10:   state_d = ABORT;
               default: state_d = IN_B;
            endcase
         end
         OUT_B: begin
            case (sens)
               2'b11:   state_d = OUT_BA;
               2'b00:   state_d = IDLE;
               2'b10:   state_d = ABORT;
               default: state_d = OUT_B;
            endcase
         end
         OUT_BA: begin
            case (sens)
               2'b10:   state_d = OUT_A;
               2'b01:   state_d = OUT_B;
               2'b00:   state_d = ABORT;
               default: state_d = OUT_BA;
            endcase
         end
         OUT_A: begin
            case (sens)
               2'b00: begin
                  state_d  = IDLE;
                  exit_evt = 1'b1;
               end
               2'b11:   state_d = OUT_BA;
               2'b01:   state_d = ABORT;
               default: state_d = OUT_A;
            endcase
         end
         default: begin
            if (sens == 2'b00) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign at_full  = (count_q == CAP_VAL);
   assign at_empty = (count_q == '0);

   // An event at a count boundary turns into a reject instead of wrapping.
   always_comb begin
      count_d  = count_q;
      enter_d  = 1'b0;
      exit_d   = 1'b0;
      reject_d = 1'b0;
      if (entry_evt) begin
         if (at_full) begin
            reject_d = 1'b1;
         end else begin
            count_d = count_q + ONE;
            enter_d = 1'b1;
         end
      end else if (exit_evt) begin
         if (at_empty) begin
            reject_d = 1'b1;
         end else begin
            count_d = count_q - ONE;
            exit_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         enter_q  <= 1'b0;
         exit_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         enter_q  <= enter_d;
         exit_q   <= exit_d;
         reject_q <= reject_d;
      end
   end

   assign count       = count_q;
   assign full        = at_full;
   assign empty       = at_empty;
   assign enter_pulse = enter_q;
   assign exit_pulse  = exit_q;
   assign reject      = reject_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl (default build, raw sensors): vector table plus
// hand-written saturation, reset-abort and back-to-back sequences.
module tb_parking_lot_ctrl;

   localparam int CAPACITY = 16;
   localparam int CNT_W    = 5;

   typedef struct {
      logic       a;
      logic       b;
      logic [4:0] cnt;
      logic       en;
      logic       ex;
      logic       rj;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             sensor_a;
   logic             sensor_b;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             enter_pulse;
   logic             exit_pulse;
   logic             reject;

   int checks = 0;
   int errors = 0;
   int model_cnt;
   vec_t vecs[$];

   parking_lot_ctrl #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .sensor_a    (sensor_a),
      .sensor_b    (sensor_b),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .enter_pulse (enter_pulse),
      .exit_pulse  (exit_pulse),
      .reject      (reject)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic apply_stimulus(input logic a, input logic b);
      @(negedge clk);
      sensor_a = a;
      sensor_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int cnt, input logic en,
                            input logic ex, input logic rj);
      check_output({tag, " count"}, int'(count), cnt);
      check_output({tag, " full"}, int'(full), (cnt == CAPACITY) ? 1 : 0);
      check_output({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
      check_output({tag, " enter_pulse"}, int'(enter_pulse), int'(en));
      check_output({tag, " exit_pulse"}, int'(exit_pulse), int'(ex));
      check_output({tag, " reject"}, int'(reject), int'(rj));
   endtask

   task automatic add_vec(input logic a, input logic b, input int cnt,
                          input logic en, input logic ex, input logic rj);
      vec_t v;
      v.a   = a;
      v.b   = b;
      v.cnt = 5'(cnt);
      v.en  = en;
      v.ex  = ex;
      v.rj  = rj;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      sensor_a = 1'b0;
      sensor_b = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One full pass; the completing 00 must produce the event one edge later.
   task automatic run_pass(input bit is_entry, input string tag);
      logic en_e, ex_e, rj_e;
      en_e = 1'b0;
      ex_e = 1'b0;
      rj_e = 1'b0;
      if (is_entry) begin
         apply_stimulus(1'b1, 1'b0);
         apply_stimulus(1'b1, 1'b1);
         apply_stimulus(1'b0, 1'b1);
         check_all({tag, " mid"}, model_cnt, 1'b0, 1'b0, 1'b0);
         apply_stimulus(1'b0, 1'b0);
         if (model_cnt < CAPACITY) begin
            model_cnt++;
            en_e = 1'b1;
         end else begin
            rj_e = 1'b1;
         end
      end else begin
         apply_stimulus(1'b0, 1'b1);
         apply_stimulus(1'b1, 1'b1);
         apply_stimulus(1'b1, 1'b0);
         check_all({tag, " mid"}, model_cnt, 1'b0, 1'b0, 1'b0);
         apply_stimulus(1'b0, 1'b0);
         if (model_cnt > 0) begin
            model_cnt--;
            ex_e = 1'b1;
         end else begin
            rj_e = 1'b1;
         end
      end
      check_all({tag, " done"}, model_cnt, en_e, ex_e, rj_e);
   endtask

   initial begin
      reset    = 1'b1;
      sensor_a = 1'b0;
      sensor_b = 1'b0;

      // Entry with 2-cycle phases
      add_vec(0, 0, 0, 0, 0, 0);
      add_vec(1, 0, 0, 0, 0, 0);
      add_vec(1, 0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 0, 0);
      add_vec(0, 1, 0, 0, 0, 0);
      add_vec(0, 1, 0, 0, 0, 0);
      add_vec(0, 0, 1, 1, 0, 0);
      add_vec(0, 0, 1, 0, 0, 0);
      // Pedestrian
      add_vec(1, 0, 1, 0, 0, 0);
      add_vec(0, 0, 1, 0, 0, 0);
      add_vec(0, 1, 1, 0, 0, 0);
      add_vec(0, 0, 1, 0, 0, 0);
      // Entry with reversal
      add_vec(1, 0, 1, 0, 0, 0);
      add_vec(1, 1, 1, 0, 0, 0);
      add_vec(1, 0, 1, 0, 0, 0);
      add_vec(1, 1, 1, 0, 0, 0);
      add_vec(0, 1, 1, 0, 0, 0);
      add_vec(0, 0, 2, 1, 0, 0);
      add_vec(0, 0, 2, 0, 0, 0);
      // Aborted pass, then IDLE
      add_vec(1, 0, 2, 0, 0, 0);
      add_vec(1, 1, 2, 0, 0, 0);
      add_vec(0, 0, 2, 0, 0, 0);
      add_vec(0, 0, 2, 0, 0, 0);
      // Exit
      add_vec(0, 1, 2, 0, 0, 0);
      add_vec(1, 1, 2, 0, 0, 0);
      add_vec(1, 0, 2, 0, 0, 0);
      add_vec(0, 0, 1, 0, 1, 0);
      // 11 from IDLE aborts; ABORT ignores 01 until 00
      add_vec(1, 1, 1, 0, 0, 0);
      add_vec(0, 1, 1, 0, 0, 0);
      add_vec(0, 0, 1, 0, 0, 0);
      // Exit with reversal in OUT_BA
      add_vec(0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 1, 0, 0, 0);
      add_vec(0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 1, 0, 0, 0);
      add_vec(1, 0, 1, 0, 0, 0);
      add_vec(0, 0, 0, 0, 1, 0);
      add_vec(0, 0, 0, 0, 0, 0);

      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("reset", 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b);
         check_all($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].en,
                   vecs[i].ex, vecs[i].rj);
      end

      // 17 back-to-back entries from empty, then 17 back-to-back exits from full
      do_reset();
      model_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         run_pass(1'b1, $sformatf("entry%0d", i));
      end
      check_output("sat full", int'(full), 1);
      for (int i = 0; i < 17; i++) begin
         run_pass(1'b0, $sformatf("exit%0d", i));
      end
      check_output("sat empty", int'(empty), 1);

      // Reset while in IN_AB at count 5 discards the pass
      do_reset();
      model_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         run_pass(1'b1, $sformatf("pre%0d", i));
      end
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b1);
      check_all("in_ab", 5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_all("mid reset", 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b1);
      check_all("post rst 01", 0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check_all("post rst 00", 0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check_all("post rst idle", 0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
